// File: rtl/jk_arb_pkg.sv
// Shared encodings for the JK bank arbiter: JK command opcodes and the statistics counter width.
package jk_arb_pkg;

    typedef enum logic [1:0] {
        JK_HOLD = 2'b00,
        JK_RST  = 2'b01,
        JK_SET  = 2'b10,
        JK_TOG  = 2'b11
    } jk_op_e;

    localparam int STAT_W = 16;

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with synchronous active-high reset and an update enable.
module jk_cell
    import jk_arb_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic j,
    input  logic k,
    output logic q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= 1'b0;
        end else if (en) begin
            case (jk_op_e'({j, k}))
                JK_HOLD: q <= q;
                JK_RST:  q <= 1'b0;
                JK_SET:  q <= 1'b1;
                JK_TOG:  q <= ~q;
            endcase
        end
    end

endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter sharing a bank of NUM_FF JK flops between NUM_REQ requesters.
// Optional per-requester grant counters are enabled by defining JK_ARB_STATS_EN.
module jk_bank_arbiter
    import jk_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int NUM_FF  = 8,
    parameter int IDX_W   = 3,
    parameter int ID_W    = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [2*NUM_REQ-1:0]     req_jk,
    input  logic [IDX_W*NUM_REQ-1:0] req_idx,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [NUM_FF-1:0]        q,
    output logic [NUM_FF-1:0]        qn,
    output logic                     gnt_valid,
    output logic [ID_W-1:0]          gnt_id,
    output logic                     busy
`ifdef JK_ARB_STATS_EN
   ,output logic [STAT_W*NUM_REQ-1:0] grant_cnt
`endif
);

    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  cand;
    logic             found;
    logic [ID_W-1:0]  gnt_sel;
    logic [1:0]       gnt_jk;
    logic [IDX_W-1:0] gnt_idx;
    logic             transfer;

    // Handshake: requester i transfers its command on a clk edge where
    // req_valid[i] & req_ready[i]; ready never depends on the command payload.
    always_comb begin
        req_ready = '0;
        cand      = rr_ptr;
        found     = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_valid[cand]) begin
                req_ready[cand] = 1'b1;
                found           = 1'b1;
            end
            cand = (cand == ID_W'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
        end
        if (reset) begin
            req_ready = '0;
        end
    end

    // Steer the granted requester's command onto the shared bank bus.
    always_comb begin
        gnt_sel = '0;
        gnt_jk  = JK_HOLD;
        gnt_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                gnt_sel = ID_W'(i);
                gnt_jk  = req_jk[2*i +: 2];
                gnt_idx = req_idx[IDX_W*i +: IDX_W];
            end
        end
    end

    assign transfer = |(req_valid & req_ready);
    assign busy     = |req_valid;
    assign qn       = ~q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr    <= '0;
            gnt_valid <= 1'b0;
            gnt_id    <= '0;
        end else begin
            gnt_valid <= transfer;
            if (transfer) begin
                gnt_id <= gnt_sel;
                rr_ptr <= (gnt_sel == ID_W'(NUM_REQ - 1)) ? '0 : gnt_sel + 1'b1;
            end
        end
    end

    // An index beyond the bank matches no cell, so the grant is consumed with no effect.
    for (genvar n = 0; n < NUM_FF; n++) begin : g_cell
        jk_cell u_cell (
            .clk   (clk),
            .reset (reset),
            .en    (transfer && (gnt_idx == IDX_W'(n))),
            .j     (gnt_jk[1]),
            .k     (gnt_jk[0]),
            .q     (q[n])
        );
    end

`ifdef JK_ARB_STATS_EN
    for (genvar r = 0; r < NUM_REQ; r++) begin : g_stat
        logic [STAT_W-1:0] cnt;

        always_ff @(posedge clk) begin
            if (reset) begin
                cnt <= '0;
            end else if (transfer && (gnt_sel == ID_W'(r)) && (cnt != '1)) begin
                cnt <= cnt + 1'b1;
            end
        end

        assign grant_cnt[STAT_W*r +: STAT_W] = cnt;
    end
`endif

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Directed self-checking bench for jk_bank_arbiter; grant counter checks run when JK_ARB_STATS_EN is defined.
module tb_jk_bank_arbiter;
    import jk_arb_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int NUM_FF  = 8;
    localparam int IDX_W   = 3;
    localparam int ID_W    = 2;

    logic                     clk;
    logic                     reset;
    logic [NUM_REQ-1:0]       req_valid;
    logic [2*NUM_REQ-1:0]     req_jk;
    logic [IDX_W*NUM_REQ-1:0] req_idx;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_FF-1:0]        q;
    logic [NUM_FF-1:0]        qn;
    logic                     gnt_valid;
    logic [ID_W-1:0]          gnt_id;
    logic                     busy;
`ifdef JK_ARB_STATS_EN
    logic [STAT_W*NUM_REQ-1:0] grant_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic [ID_W-1:0] exp_q[$];
    logic [2:0] tog_exp;

    jk_bank_arbiter #(
        .NUM_REQ (NUM_REQ),
        .NUM_FF  (NUM_FF),
        .IDX_W   (IDX_W),
        .ID_W    (ID_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_jk    (req_jk),
        .req_idx   (req_idx),
        .req_ready (req_ready),
        .q         (q),
        .qn        (qn),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .busy      (busy)
`ifdef JK_ARB_STATS_EN
       ,.grant_cnt (grant_cnt)
`endif
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [1:0] jk, input logic [IDX_W-1:0] idx);
        req_valid[i]             = v;
        req_jk[2*i +: 2]         = jk;
        req_idx[IDX_W*i +: IDX_W] = idx;
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_jk    = '0;
        req_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, JK_SET, IDX_W'(i));

        // reset held for two edges with every requester valid
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", req_ready, 0);
        check("rst_q", q, 0);
        check("rst_qn", qn, 8'hFF);
        check("rst_gnt_valid", gnt_valid, 0);
        check("rst_gnt_id", gnt_id, 0);
        check("rst_busy", busy, 1);

        // all valid, SET own index: grants 0,1,2,3
        reset = 1'b0;
        #1;
        for (int c = 0; c < 4; c++) begin
            check("rr_ready", req_ready, 64'(1 << c));
            exp_q.push_back(ID_W'(c));
            @(negedge clk);
            check("rr_gnt_valid", gnt_valid, 1);
            check("rr_gnt_id", gnt_id, exp_q.pop_front());
            check("rr_q", q, 64'((1 << (c + 1)) - 1));
            #1;
        end
        req_valid = '0;
        #1;
        check("idle_busy", busy, 0);
        check("idle_ready", req_ready, 0);
        @(negedge clk);
        check("idle_gnt_valid", gnt_valid, 0);
        check("idle_gnt_id_hold", gnt_id, 3);
        check("idle_q", q, 8'h0F);

        // req 2 alone toggles idx 5 three times
        tog_exp = 3'b101;
        set_req(2, 1'b1, JK_TOG, 3'd5);
        for (int t = 0; t < 3; t++) begin
            #1;
            check("tog_ready", req_ready, 4'b0100);
            @(negedge clk);
            check("tog_q5", q[5], tog_exp[t]);
            check("tog_gnt_id", gnt_id, 2);
        end
        req_valid = '0;

        // HOLD from req 1 consumes a grant, leaving the pointer at 2
        set_req(1, 1'b1, JK_HOLD, 3'd0);
        #1;
        check("hold_ready", req_ready, 4'b0010);
        @(negedge clk);
        check("hold_q", q, 8'h2F);
        check("hold_gnt_id", gnt_id, 1);

        // contention on idx 7 with pointer at 2: req 3 wins, then req 1
        set_req(1, 1'b1, JK_RST, 3'd7);
        set_req(3, 1'b1, JK_SET, 3'd7);
        #1;
        check("cont_ready_a", req_ready, 4'b1000);
        @(negedge clk);
        check("cont_q_a", q, 8'hAF);
        check("cont_gnt_id_a", gnt_id, 3);
        set_req(3, 1'b0, JK_SET, 3'd7);
        #1;
        check("cont_ready_b", req_ready, 4'b0010);
        @(negedge clk);
        check("cont_q_b", q, 8'h2F);
        check("cont_gnt_id_b", gnt_id, 1);
        req_valid = '0;

        // reset during a SET to idx 4 discards it and returns the pointer to 0
        set_req(2, 1'b1, JK_SET, 3'd4);
        reset = 1'b1;
        #1;
        check("rst2_ready", req_ready, 0);
        @(negedge clk);
        check("rst2_q", q, 0);
        check("rst2_gnt_valid", gnt_valid, 0);
        check("rst2_gnt_id", gnt_id, 0);
        reset = 1'b0;
        set_req(0, 1'b1, JK_SET, 3'd1);
        #1;
        check("rst2_ptr_ready", req_ready, 4'b0001);
        @(negedge clk);
        check("rst2_q_a", q, 8'h02);
        check("rst2_gnt_id_a", gnt_id, 0);
        #1;
        check("rst2_ready_b", req_ready, 4'b0100);
        @(negedge clk);
        check("rst2_q_b", q, 8'h12);
        check("rst2_gnt_id_b", gnt_id, 2);
        req_valid = '0;

`ifdef JK_ARB_STATS_EN
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("cnt_rst", grant_cnt, 0);
        set_req(0, 1'b1, JK_HOLD, 3'd0);
        repeat (5) @(negedge clk);
        check("cnt_five", grant_cnt, 64'd5);
        repeat (65535) @(negedge clk);
        check("cnt_sat", grant_cnt, 64'hFFFF);
        repeat (3) @(negedge clk);
        check("cnt_sat_hold", grant_cnt, 64'hFFFF);
        req_valid = '0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
